// File: rtl/muldiv_pkg.sv
// ============================================================================
// Module   : muldiv_pkg
// Purpose  : Shared funct3 codes, FSM state encoding and helpers for the
//            RV32M multiply/divide unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam int MULDIV_ITERS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Magnitude of x when it is treated as a signed value, otherwise x itself.
    function automatic logic [31:0] abs32(input logic [31:0] x, input logic is_signed);
        return (is_signed && x[31]) ? -x : x;
    endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_iter_core.sv
// ============================================================================
// Module   : muldiv_iter_core
// Purpose  : One radix-2 step on a {hi,lo} accumulator: shift-add multiply or
//            restoring divide, selected by is_div_i.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_iter_core #(
    parameter int W = 32
) (
    input  logic           is_div_i,
    input  logic [2*W-1:0] acc_i,
    input  logic [W-1:0]   operand_i,
    output logic [2*W-1:0] acc_o
);

    logic [W-1:0] w_hi;
    logic [W-1:0] w_lo;
    logic [W:0]   w_sum;
    logic [W:0]   w_shift;
    logic [W-1:0] w_diff;

    always_comb begin
        w_hi    = acc_i[2*W-1:W];
        w_lo    = acc_i[W-1:0];
        w_sum   = {1'b0, w_hi} + (w_lo[0] ? {1'b0, operand_i} : {(W+1){1'b0}});
        w_shift = {w_hi, w_lo[W-1]};
        // Only used when w_shift >= divisor, so the dropped top bit is zero.
        w_diff  = w_shift[W-1:0] - operand_i;
        acc_o   = acc_i;
        if (is_div_i) begin
            if (w_shift >= {1'b0, operand_i}) begin
                acc_o = {w_diff, w_lo[W-2:0], 1'b1};
            end else begin
                acc_o = {w_shift[W-1:0], w_lo[W-2:0], 1'b0};
            end
        end else begin
            acc_o = {w_sum, w_lo[W-1:1]};
        end
    end

endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Iterative RV32M multiply/divide unit with register write-back.
//            MULDIV_FAST_MUL_EN selects a single-cycle multiplier path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [2:0]                   funct3,
    input  logic [DATA_WIDTH-1:0]        operand_a,
    input  logic [DATA_WIDTH-1:0]        operand_b,
    input  logic [$clog2(REG_COUNT)-1:0] rd_in,
    output logic                         busy,
    output logic                         done,
    output logic [DATA_WIDTH-1:0]        result,
    output logic [$clog2(REG_COUNT)-1:0] rd_out,
    output logic                         wb_reg_write
);

    import muldiv_pkg::*;

    localparam int DW = DATA_WIDTH;
    localparam int RW = $clog2(REG_COUNT);

    state_t          state_q, state_d;
    logic [5:0]      cnt_q, cnt_d;
    logic [2:0]      op_q, op_d;
    logic [2*DW-1:0] acc_q, acc_d;
    logic [DW-1:0]   opnd_q, opnd_d;
    logic            neg_q, neg_d;
    logic [DW-1:0]   result_q, result_d;
    logic [RW-1:0]   rd_q, rd_d;

    logic            w_is_div, w_a_signed, w_b_signed, w_sa, w_sb;
    logic            w_neg, w_div0, w_ovf;
    logic [DW-1:0]   w_mag_a, w_mag_b, w_special, w_rem_fix;
    logic [2*DW-1:0] w_core_acc, w_acc_fix;

    muldiv_iter_core #(.W(DW)) u_core (
        .is_div_i  (op_q[2]),
        .acc_i     (acc_q),
        .operand_i (opnd_q),
        .acc_o     (w_core_acc)
    );

    always_comb begin
        w_is_div   = funct3[2];
        w_a_signed = (funct3 != F3_MULHU) && (funct3 != F3_DIVU) && (funct3 != F3_REMU);
        w_b_signed = (funct3 == F3_MUL) || (funct3 == F3_MULH) ||
                     (funct3 == F3_DIV) || (funct3 == F3_REM);
        w_sa       = w_a_signed & operand_a[DW-1];
        w_sb       = w_b_signed & operand_b[DW-1];
        w_mag_a    = abs32(operand_a, w_a_signed);
        w_mag_b    = abs32(operand_b, w_b_signed);
        // Remainder follows the dividend; quotient and product use the XOR.
        w_neg      = (w_is_div && funct3[1]) ? w_sa : (w_sa ^ w_sb);
        w_div0     = w_is_div && (operand_b == '0);
        w_ovf      = w_is_div && w_a_signed && (operand_b == '1) &&
                     (operand_a == {1'b1, {(DW-1){1'b0}}});
        if (funct3[1]) begin
            w_special = w_div0 ? operand_a : '0;
        end else begin
            w_special = w_div0 ? '1 : {1'b1, {(DW-1){1'b0}}};
        end
        w_acc_fix  = neg_q ? -acc_q : acc_q;
        w_rem_fix  = neg_q ? -acc_q[2*DW-1:DW] : acc_q[2*DW-1:DW];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        neg_d    = neg_q;
        result_d = result_q;
        rd_d     = rd_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d  = funct3;
                    rd_d  = rd_in;
                    neg_d = w_neg;
                    cnt_d = '0;
                    // Divide keeps the dividend in lo; multiply keeps the multiplier.
                    if (w_is_div) begin
                        acc_d  = {{DW{1'b0}}, w_mag_a};
                        opnd_d = w_mag_b;
                    end else begin
                        acc_d  = {{DW{1'b0}}, w_mag_b};
                        opnd_d = w_mag_a;
                    end
                    if (w_div0 || w_ovf) begin
                        result_d = w_special;
                        state_d  = DONE;
                    end else begin
`ifdef MULDIV_FAST_MUL_EN
                        if (w_is_div) begin
                            state_d = CALC;
                        end else begin
                            acc_d   = {{DW{1'b0}}, w_mag_a} * {{DW{1'b0}}, w_mag_b};
                            state_d = FIX;
                        end
`else
                        state_d = CALC;
`endif
                    end
                end
            end
            CALC: begin
                acc_d = w_core_acc;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'(MULDIV_ITERS - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (op_q[2]) begin
                    result_d = op_q[1] ? w_rem_fix : w_acc_fix[DW-1:0];
                end else begin
                    result_d = (op_q == F3_MUL) ? w_acc_fix[DW-1:0] : w_acc_fix[2*DW-1:DW];
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
            rd_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            rd_q     <= rd_d;
        end
    end

    assign busy         = (state_q != IDLE);
    assign done         = (state_q == DONE);
    assign result       = result_q;
    assign rd_out       = rd_q;
    assign wb_reg_write = done && (rd_q != '0);

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// Module   : tb_muldiv_unit
// Purpose  : Directed self-checking bench for muldiv_unit with a scoreboard
//            queue; honours MULDIV_FAST_MUL_EN for multiply latency.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_muldiv_unit;

    import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 34;
`endif
    localparam int DIV_LAT = 34;
    localparam int SPC_LAT = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [4:0]  rd_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;
    logic        wb_reg_write;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        wb;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    muldiv_unit #(.DATA_WIDTH(32), .REG_COUNT(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .funct3       (funct3),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .rd_in        (rd_in),
        .busy         (busy),
        .done         (done),
        .result       (result),
        .rd_out       (rd_out),
        .wb_reg_write (wb_reg_write)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issues one op, scrambles inputs after the start edge and checks the
    // completion against the scoreboard. restart_at>0 re-pulses start then.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp_res, input int exp_lat, input int restart_at);
        exp_t e;
        int   lat;
        int   busy_cyc;
        @(negedge clk);
        start     = 1'b1;
        funct3    = f3;
        operand_a = a;
        operand_b = b;
        rd_in     = rd;
        sb.push_back('{res: exp_res, rd: rd, wb: (rd != 5'd0), lat: exp_lat});
        @(posedge clk);
        lat      = 1;
        busy_cyc = 0;
        @(negedge clk);
        start     = 1'b0;
        funct3    = 3'($urandom);
        operand_a = $urandom;
        operand_b = $urandom;
        rd_in     = 5'($urandom);
        while (1) begin
            if (busy) busy_cyc++;
            if (done || lat >= 100) break;
            start = (restart_at > 0 && lat == restart_at);
            @(posedge clk);
            lat++;
            @(negedge clk);
            start = 1'b0;
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_latency"}, 32'(lat), 32'(e.lat));
            chk({tag, "_busy_cycles"}, 32'(busy_cyc), 32'(e.lat));
            chk({tag, "_result"}, result, e.res);
            chk({tag, "_rd_out"}, 32'(rd_out), 32'(e.rd));
            chk({tag, "_wb"}, 32'(wb_reg_write), 32'(e.wb));
        end
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int seen;
        reset     = 1'b1;
        start     = 1'b0;
        funct3    = 3'd0;
        operand_a = 32'd0;
        operand_b = 32'd0;
        rd_in     = 5'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_wb", 32'(wb_reg_write), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_rd_out", 32'(rd_out), 32'd0);
        reset = 1'b0;

        run_op("mul",    F3_MUL,    32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, MUL_LAT, 0);
        run_op("mulh",   F3_MULH,   32'h8000_0000,  32'h8000_0000, 5'd6,  32'h4000_0000, MUL_LAT, 0);
        run_op("mulhu",  F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE, MUL_LAT, 0);
        run_op("mulhsu", F3_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF, MUL_LAT, 0);
        run_op("div",    F3_DIV,    32'hFFFF_FFF9,  32'd2,         5'd9,  32'hFFFF_FFFD, DIV_LAT, 0);
        run_op("rem",    F3_REM,    32'hFFFF_FFF9,  32'd2,         5'd10, 32'hFFFF_FFFF, DIV_LAT, 0);
        run_op("divu",   F3_DIVU,   32'd100,        32'd7,         5'd11, 32'd14,        DIV_LAT, 0);
        run_op("remu",   F3_REMU,   32'd100,        32'd7,         5'd12, 32'd2,         DIV_LAT, 0);
        run_op("div0",   F3_DIV,    32'd5,          32'd0,         5'd13, 32'hFFFF_FFFF, SPC_LAT, 0);
        run_op("remu0",  F3_REMU,   32'd5,          32'd0,         5'd14, 32'd5,         SPC_LAT, 0);
        run_op("divovf", F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd15, 32'h8000_0000, SPC_LAT, 0);
        run_op("removf", F3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd16, 32'd0,         SPC_LAT, 0);
        run_op("restart", F3_DIVU,  32'd100,        32'd7,         5'd17, 32'd14,        DIV_LAT, 3);
        run_op("rd0",    F3_MUL,    32'd3,          32'd4,         5'd0,  32'd12,        MUL_LAT, 0);

        // Abort a divide 10 edges in; nothing may complete afterwards.
        @(negedge clk);
        start     = 1'b1;
        funct3    = F3_DIV;
        operand_a = 32'd1000;
        operand_b = 32'd3;
        rd_in     = 5'd9;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_result", result, 32'd0);
        chk("abort_rd_out", 32'(rd_out), 32'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("abort_no_done", 32'(seen), 32'd0);

        run_op("recover", F3_REMU,  32'd100,        32'd7,         5'd3,  32'd2,         DIV_LAT, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit in the single-cycle CPU.
- Consumes the two register-file read operands and the destination register index.
- Produces the write-back result, destination index and write enable that feed the register-file write port.
- While it computes, busy stalls the PC/issue logic; the unit holds all state between start and done.

Parameters:
- DATA_WIDTH, 32, operand/result width; only 32 is supported.
- REG_COUNT, 32, register count; index width is $clog2(REG_COUNT).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- operand_a  input  DATA_WIDTH  rs1 value (read_data1).
- operand_b  input  DATA_WIDTH  rs2 value (read_data2).
- rd_in  input  $clog2(REG_COUNT)  destination register index.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse; result valid.
- result  output  DATA_WIDTH  write_data to the register file.
- rd_out  output  $clog2(REG_COUNT)  write_reg to the register file.
- wb_reg_write  output  1  equals done && (rd_out != 0).

Behaviour:
- Reset (sync, any state, including mid-operation): state=IDLE; busy, done, wb_reg_write=0; result=0; rd_out=0. No done is ever produced for an aborted operation.
- States: IDLE, CALC, FIX, DONE.
- IDLE + start at edge E0:
  - Capture funct3, operands and rd_in. Inputs are ignored thereafter.
  - Compute magnitudes: signed ops use |x|; MULHSU takes |a| only.
  - Record the result sign.
  - Clear the 6-bit iteration counter.
- Special cases resolved at E0, next state DONE (done high in the cycle after E0):
  - Divide by zero: DIV/DIVU result=0xFFFFFFFF; REM/REMU result=operand_a.
  - Signed overflow (a=0x80000000, b=0xFFFFFFFF): DIV result=0x80000000; REM result=0.
- Otherwise next state CALC.
- CALC: one radix-2 step per edge, 32 steps (E1..E32); at E32 -> FIX.
  - Multiply: shift-add into a 64-bit product.
  - Divide: restoring step on a 64-bit remainder/quotient pair.
- FIX (E33):
  - Apply two's-complement sign correction to the 64-bit product / quotient / remainder.
  - Select result: MUL low 32 bits; MULH* high 32 bits; DIV* quotient; REM* remainder.
  - Register result; -> DONE.
- Sign rules:
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder sign = sign(a).
  - Product sign = XOR of the signed operand signs.
- DONE: done=1 for exactly one cycle; result and rd_out stable; next edge -> IDLE.
- Normal latency: done is high in the cycle after E33 (34 edges after the start edge). busy is high from the cycle after E0 through the DONE cycle inclusive.
- start while busy (including during DONE) is ignored; no queueing. start may be asserted again in the cycle after done falls.
- result and rd_out hold their last values in IDLE; they are meaningful only when done=1.
- rd_in=0: the operation completes and done pulses, but wb_reg_write stays 0.

Optional Feature:
- MULDIV_FAST_MUL_EN defined:
  - MUL/MULH/MULHSU/MULHU use a single-cycle 64-bit signed/unsigned multiply registered at E0; the state goes to FIX.
  - done is high in the cycle after E1 (latency 2).
  - Divides are unchanged.
- Undefined: all multiplies use the iterative 34-edge path.

Decomposition:
- Shared package muldiv_pkg:
  - funct3 localparams (F3_MUL..F3_REMU).
  - State encoding IDLE=2'd0, CALC=2'd1, FIX=2'd2, DONE=2'd3.
  - MULDIV_ITERS=32.
- One sub-module, muldiv_iter_core: combinational single-step shift-add / restoring-subtract on a {hi,lo} 64-bit accumulator, selected by an is_div input. The FSM, counter, sign handling and special cases stay in muldiv_unit.

Test Plan:
- MUL a=7, b=0xFFFFFFFD, rd_in=5 -> result 0xFFFFFFEB, rd_out=5, wb_reg_write=1; done exactly 34 cycles after the start edge; busy high 34 cycles.
- High multiplies:
  - MULH 0x80000000 × 0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF.
- Divides:
  - DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD.
  - REM 0xFFFFFFF9 / 2 -> 0xFFFFFFFF.
  - DIVU 100 / 7 -> 14.
  - REMU 100 / 7 -> 2.
- Corner cases, each with done in the cycle after the start edge:
  - DIV 5 / 0 -> 0xFFFFFFFF.
  - REMU 5 / 0 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
  - REM 0x80000000 / 0xFFFFFFFF -> 0.
- Control:
  - Second start 3 cycles into a DIV is ignored; result matches the first op only.
  - reset asserted 10 cycles into a DIV -> busy=0 next cycle, no done pulse.
  - MUL with rd_in=0 -> done=1, wb_reg_write=0.
- With MULDIV_FAST_MUL_EN: MUL 7 × 0xFFFFFFFD -> 0xFFFFFFEB with done 2 cycles after the start edge; DIVU 100 / 7 still takes 34.
